pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_pkg.sv | 26 ++
 rtl/pc_ras.sv | 67 ++++++
 rtl/pc_sequencer.sv | 97 +++++++++
 tb/tb_pc_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared definitions for pc_sequencer: the Selector opcode enum and its constants.
package pc_seq_pkg;

    localparam logic [2:0] SEL_HOLD   = 3'd0;
    localparam logic [2:0] SEL_SEQ    = 3'd1;
    localparam logic [2:0] SEL_BRANCH = 3'd2;
    localparam logic [2:0] SEL_JUMP   = 3'd3;
    localparam logic [2:0] SEL_CALL   = 3'd4;
    localparam logic [2:0] SEL_RET    = 3'd5;

    typedef enum logic [2:0] {
        OP_HOLD   = SEL_HOLD,
        OP_SEQ    = SEL_SEQ,
        OP_BRANCH = SEL_BRANCH,
        OP_JUMP   = SEL_JUMP,
        OP_CALL   = SEL_CALL,
        OP_RET    = SEL_RET,
        OP_RSV6   = 3'd6,
        OP_RSV7   = 3'd7
    } pc_op_e;

    function automatic pc_op_e decode_op(input logic [2:0] sel);
        return pc_op_e'(sel);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// a pop when empty leaves the stack untouched; both raise a combinational flag.
module pc_ras #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign full      = (cnt_q == CNT_MAX);
    assign empty     = (cnt_q == '0);
    assign overflow  = push && full;
    assign underflow = pop && empty;
    assign rdata     = mem_q[top_q - PTR_ONE];

    // top_q always names the next write slot; when full that slot holds the oldest entry.
    always_comb begin
        mem_d = mem_q;
        top_d = top_q;
        cnt_d = cnt_q;
        if (push) begin
            mem_d[top_q] = wdata;
            top_d        = top_q + PTR_ONE;
            if (!full) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (pop && !empty) begin
            top_d = top_q - PTR_ONE;
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer (HOLD/SEQ/BRANCH/JUMP/CALL/RET).
// Define PC_SEQ_RAS_EN to build the return-address stack; otherwise CALL=JUMP, RET=SEQ.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned      XLEN      = 32,
    parameter logic [XLEN-1:0]  RST_VEC   = '0,
    parameter int unsigned      STEP      = 4,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [2:0]      Selector,
    input  logic [XLEN-1:0] in_pc,
    output logic [XLEN-1:0] out_pc,
    output logic            ras_full,
    output logic            ras_empty,
    output logic            ras_err
);

    localparam logic [XLEN-1:0] STEP_V = XLEN'(STEP);

    pc_op_e          op;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [XLEN-1:0] seq_pc;

    assign op     = decode_op(Selector);
    assign seq_pc = out_pc_q + STEP_V;
    assign out_pc = out_pc_q;

`ifdef PC_SEQ_RAS_EN
    logic            ras_push, ras_pop;
    logic [XLEN-1:0] ras_rdata;
    logic            ras_ovf, ras_unf;
    logic            ras_err_q, ras_err_d;

    assign ras_push = en && (op == OP_CALL);
    assign ras_pop  = en && (op == OP_RET);

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (XLEN)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .wdata     (seq_pc),
        .rdata     (ras_rdata),
        .full      (ras_full),
        .empty     (ras_empty),
        .overflow  (ras_ovf),
        .underflow (ras_unf)
    );

    assign ras_err_d = ras_ovf || ras_unf;
    assign ras_err   = ras_err_q;
`else
    assign ras_full  = 1'b0;
    assign ras_empty = 1'b1;
    assign ras_err   = 1'b0;
`endif

    always_comb begin
        out_pc_d = out_pc_q;
        if (en) begin
            case (op)
                OP_SEQ:    out_pc_d = seq_pc;
                OP_BRANCH: out_pc_d = out_pc_q + in_pc;
                OP_JUMP:   out_pc_d = in_pc;
                OP_CALL:   out_pc_d = in_pc;
`ifdef PC_SEQ_RAS_EN
                OP_RET:    out_pc_d = ras_empty ? seq_pc : ras_rdata;
`else
                OP_RET:    out_pc_d = seq_pc;
`endif
                default:   out_pc_d = out_pc_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_pc_q <= RST_VEC;
`ifdef PC_SEQ_RAS_EN
            ras_err_q <= 1'b0;
`endif
        end else begin
            out_pc_q <= out_pc_d;
`ifdef PC_SEQ_RAS_EN
            ras_err_q <= ras_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer against a queue-based reference model;
// adapts its expectations to whether PC_SEQ_RAS_EN is defined.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [2:0]  sel = 3'd0;
    logic [31:0] in_pc = '0;
    logic [31:0] out_pc;
    logic        ras_full, ras_empty, ras_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc  = '0;
    logic        m_err = 1'b0;
    logic [31:0] m_stk [$];

`ifdef PC_SEQ_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    pc_sequencer #(
        .XLEN      (32),
        .RST_VEC   (32'h0),
        .STEP      (4),
        .RAS_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .Selector  (sel),
        .in_pc     (in_pc),
        .out_pc    (out_pc),
        .ras_full  (ras_full),
        .ras_empty (ras_empty),
        .ras_err   (ras_err)
    );

    always #5 clk = ~clk;

    function automatic logic exp_full();
        return RAS_ON && (m_stk.size() == 4);
    endfunction

    function automatic logic exp_empty();
        return !RAS_ON || (m_stk.size() == 0);
    endfunction

    // Drive one cycle, advance the model by the operation's stated effect, settle past the edge.
    task automatic step(input logic r, input logic e, input logic [2:0] s, input logic [31:0] d);
        rst = r; en = e; sel = s; in_pc = d;
        m_err = 1'b0;
        if (r) begin
            m_pc = 32'h0;
            m_stk.delete();
        end else if (e) begin
            case (s)
                3'd1: m_pc = m_pc + 32'd4;
                3'd2: m_pc = m_pc + d;
                3'd3: m_pc = d;
                3'd4: begin
                    if (RAS_ON) begin
                        m_err = (m_stk.size() == 4);
                        m_stk.push_back(m_pc + 32'd4);
                        if (m_stk.size() > 4) void'(m_stk.pop_front());
                    end
                    m_pc = d;
                end
                3'd5: begin
                    if (RAS_ON && m_stk.size() > 0) m_pc = m_stk.pop_back();
                    else begin
                        m_err = RAS_ON;
                        m_pc  = m_pc + 32'd4;
                    end
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 3'd3, 32'hDEAD_BEEF);
            total++;
            if (out_pc !== 32'h0 || ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_err !== 1'b0) begin
                bad++;
                $display("FAIL reset_state pc=%h empty=%b full=%b err=%b want pc=0 empty=1 full=0 err=0",
                         out_pc, ras_empty, ras_full, ras_err);
            end
        end
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b1, 3'd1, 32'h0);
            total++;
            if (out_pc !== 32'(i * 4) || ras_empty !== 1'b1) begin
                bad++;
                $display("FAIL seq_after_reset pc=%h empty=%b want pc=%h empty=1", out_pc, ras_empty, 32'(i * 4));
            end
        end
    endtask

    task automatic test_branch_jump();
        step(1'b0, 1'b1, 3'd3, 32'h10);
        step(1'b0, 1'b1, 3'd2, 32'hFFFF_FFF8);
        total++;
        if (out_pc !== 32'h8) begin
            bad++;
            $display("FAIL branch_back pc=%h want=%h", out_pc, 32'h8);
        end
        step(1'b0, 1'b1, 3'd3, 32'hFFFF_FFFC);
        total++;
        if (out_pc !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL jump_top pc=%h want=%h", out_pc, 32'hFFFF_FFFC);
        end
        step(1'b0, 1'b1, 3'd1, 32'h0);
        total++;
        if (out_pc !== 32'h0 || ras_err !== 1'b0) begin
            bad++;
            $display("FAIL seq_wrap pc=%h err=%b want pc=0 err=0", out_pc, ras_err);
        end
        step(1'b0, 1'b1, 3'd6, 32'h1234);
        step(1'b0, 1'b1, 3'd7, 32'h5678);
        total++;
        if (out_pc !== 32'h0) begin
            bad++;
            $display("FAIL reserved_hold pc=%h want=%h", out_pc, 32'h0);
        end
    endtask

    task automatic test_call_ret();
        step(1'b0, 1'b1, 3'd3, 32'h20);
        step(1'b0, 1'b1, 3'd4, 32'h100);
        total++;
        if (out_pc !== 32'h100 || ras_empty !== !RAS_ON) begin
            bad++;
            $display("FAIL call pc=%h empty=%b want pc=100 empty=%b", out_pc, ras_empty, !RAS_ON);
        end
        step(1'b0, 1'b1, 3'd5, 32'h0);
        total++;
        if (out_pc !== (RAS_ON ? 32'h24 : 32'h104) || ras_empty !== 1'b1 || ras_err !== 1'b0) begin
            bad++;
            $display("FAIL ret pc=%h empty=%b err=%b want pc=%h empty=1 err=0",
                     out_pc, ras_empty, ras_err, RAS_ON ? 32'h24 : 32'h104);
        end
    endtask

    task automatic test_nested();
        step(1'b0, 1'b1, 3'd3, 32'h40);
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b1, 3'd4, 32'(i * 32'h1000));
            total++;
            if (out_pc !== m_pc || ras_full !== (RAS_ON && i >= 4) || ras_err !== (RAS_ON && i == 5)) begin
                bad++;
                $display("FAIL nested_call%0d pc=%h full=%b err=%b want pc=%h full=%b err=%b",
                         i, out_pc, ras_full, ras_err, m_pc, RAS_ON && i >= 4, RAS_ON && i == 5);
            end
        end
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b1, 3'd5, 32'h0);
            total++;
            if (out_pc !== m_pc || ras_err !== m_err || ras_empty !== exp_empty()) begin
                bad++;
                $display("FAIL nested_ret%0d pc=%h err=%b empty=%b want pc=%h err=%b empty=%b",
                         i, out_pc, ras_err, ras_empty, m_pc, m_err, exp_empty());
            end
        end
        total++;
        if (RAS_ON && out_pc !== 32'h1008) begin
            bad++;
            $display("FAIL ret_underflow_pc pc=%h want=%h", out_pc, 32'h1008);
        end
        step(1'b0, 1'b1, 3'd0, 32'h0);
        total++;
        if (ras_err !== 1'b0) begin
            bad++;
            $display("FAIL err_one_cycle err=%b want=0", ras_err);
        end
    endtask

    task automatic test_stall_reset();
        step(1'b0, 1'b1, 3'd3, 32'h300);
        step(1'b0, 1'b0, 3'd3, 32'h500);
        total++;
        if (out_pc !== 32'h300 || ras_err !== 1'b0) begin
            bad++;
            $display("FAIL stall_jump pc=%h err=%b want pc=300 err=0", out_pc, ras_err);
        end
        step(1'b0, 1'b0, 3'd5, 32'h0);
        total++;
        if (out_pc !== 32'h300 || ras_err !== 1'b0 || ras_empty !== 1'b1) begin
            bad++;
            $display("FAIL stall_ret pc=%h err=%b empty=%b want pc=300 err=0 empty=1", out_pc, ras_err, ras_empty);
        end
        step(1'b0, 1'b1, 3'd4, 32'h600);
        step(1'b0, 1'b1, 3'd4, 32'h700);
        step(1'b1, 1'b1, 3'd4, 32'h800);
        total++;
        if (out_pc !== 32'h0 || ras_empty !== 1'b1 || ras_full !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_calls pc=%h empty=%b full=%b want pc=0 empty=1 full=0",
                     out_pc, ras_empty, ras_full);
        end
        step(1'b0, 1'b1, 3'd5, 32'h0);
        total++;
        if (out_pc !== 32'h4 || ras_err !== RAS_ON) begin
            bad++;
            $display("FAIL ret_after_reset pc=%h err=%b want pc=4 err=%b", out_pc, ras_err, RAS_ON);
        end
    endtask

    task automatic test_random();
        logic        r, e;
        logic [2:0]  s;
        logic [31:0] d;
        for (int n = 0; n < 400; n++) begin
            r = ($urandom_range(0, 99) < 3);
            e = ($urandom_range(0, 99) < 80);
            s = 3'($urandom_range(0, 7));
            d = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($signed($urandom_range(0, 64)) - 32);
            step(r, e, s, d);
            total++;
            if (out_pc !== m_pc || ras_err !== m_err || ras_full !== exp_full() || ras_empty !== exp_empty()) begin
                bad++;
                $display("FAIL random%0d pc=%h err=%b full=%b empty=%b want pc=%h err=%b full=%b empty=%b",
                         n, out_pc, ras_err, ras_full, ras_empty, m_pc, m_err, exp_full(), exp_empty());
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_branch_jump();
        test_call_ret();
        test_nested();
        test_stall_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
